// File: rtl/regfile_arb_pkg.sv
// Shared types for the 1r1w register-file arbiter: controller states and request-type encoding.
package regfile_arb_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

endpackage

// File: rtl/regfile_arb_1r1w_rr_arb_2.sv
// Two-requester round-robin arbiter; after every transfer priority moves to the requester that lost.
module rr_arb_2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic val0,
    input  logic val1,
    input  logic xfer,
    output logic rdy0,
    output logic rdy1,
    output logic grant
);

    logic prio_reg;

    // Ready depends only on the other requester's val, never on the port's own.
    assign rdy0  = en && (!val1 || !prio_reg);
    assign rdy1  = en && (!val0 ||  prio_reg);
    assign grant = !(val0 && rdy0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_reg <= 1'b0;
        end else if (xfer) begin
            prio_reg <= ~grant;
        end
    end

endmodule

// File: rtl/regfile_arb_1r1w.sv
// Controller owning a 1r1w register file: zero-fill sweep after reset/clear, then round-robin
// sharing between two val/rdy requesters with latency-1 registered read responses.
module regfile_arb_1r1w
    import regfile_arb_pkg::*;
#(
    parameter int p_nbits = 4,
    parameter int p_nregs = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    output logic                       init_done,
    input  logic                       req0_val,
    output logic                       req0_rdy,
    input  logic                       req0_wr,
    input  logic [$clog2(p_nregs)-1:0] req0_addr,
    input  logic [p_nbits-1:0]         req0_wdata,
    input  logic                       req1_val,
    output logic                       req1_rdy,
    input  logic                       req1_wr,
    input  logic [$clog2(p_nregs)-1:0] req1_addr,
    input  logic [p_nbits-1:0]         req1_wdata,
    output logic                       resp0_val,
    output logic [p_nbits-1:0]         resp0_data,
    output logic                       resp1_val,
    output logic [p_nbits-1:0]         resp1_data,
    output logic                       rf_wen,
    output logic [$clog2(p_nregs)-1:0] rf_waddr,
    output logic [p_nbits-1:0]         rf_wdata,
    output logic [$clog2(p_nregs)-1:0] rf_raddr,
    input  logic [p_nbits-1:0]         rf_rdata
);

    localparam int p_awidth = $clog2(p_nregs);
    localparam logic [p_awidth-1:0] LAST = p_awidth'(p_nregs - 1);

    state_t              state_reg;
    logic [p_awidth-1:0] cnt_reg;
    logic                init_done_reg;

    logic                rdy0, rdy1, grant, xfer;
    logic                sel_wr;
    logic [p_awidth-1:0] sel_addr;
    logic [p_nbits-1:0]  sel_wdata;
    logic [1:0]          val_a, wr_a, rdy_a;

    rr_arb_2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state_reg == SERVE),
        .val0  (req0_val),
        .val1  (req1_val),
        .xfer  (xfer),
        .rdy0  (rdy0),
        .rdy1  (rdy1),
        .grant (grant)
    );

    assign xfer      = (req0_val && rdy0) || (req1_val && rdy1);
    assign sel_wr    = grant ? req1_wr    : req0_wr;
    assign sel_addr  = grant ? req1_addr  : req0_addr;
    assign sel_wdata = grant ? req1_wdata : req0_wdata;

    assign req0_rdy  = rdy0;
    assign req1_rdy  = rdy1;
    assign init_done = init_done_reg;

    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        rf_raddr = '0;
        if (state_reg == INIT) begin
            rf_wen   = 1'b1;
            rf_waddr = cnt_reg;
        end else if (xfer) begin
            if (sel_wr == WR) begin
                rf_wen   = 1'b1;
                rf_waddr = sel_addr;
                rf_wdata = sel_wdata;
            end else begin
                rf_raddr = sel_addr;
            end
        end
    end

    // The counter wraps to zero on the last sweep write, so SERVE always starts with it cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= INIT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
        end else if (clear) begin
            state_reg     <= INIT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        state_reg     <= SERVE;
                        init_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    assign val_a = {req1_val, req0_val};
    assign wr_a  = {req1_wr, req0_wr};
    assign rdy_a = {rdy1, rdy0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            logic               rd_xfer;
            logic               val_reg;
            logic [p_nbits-1:0] data_reg;

            assign rd_xfer = val_a[gi] && rdy_a[gi] && (wr_a[gi] == RD);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    val_reg  <= 1'b0;
                    data_reg <= '0;
                end else begin
                    val_reg <= rd_xfer;
                    if (rd_xfer) begin
                        data_reg <= rf_rdata;
                    end
                end
            end
        end
    endgenerate

    assign resp0_val  = g_resp[0].val_reg;
    assign resp0_data = g_resp[0].data_reg;
    assign resp1_val  = g_resp[1].val_reg;
    assign resp1_data = g_resp[1].data_reg;

endmodule

// File: tb/tb_regfile_arb_1r1w.sv
// Bench for regfile_arb_1r1w: directed vector table, hand-written clear/reset sequences,
// then random traffic checked against an array-based reference model.
module tb_regfile_arb_1r1w;

    localparam int NR = 4;
    localparam int NV = 17;

    logic       clk = 1'b0;
    logic       rst, clear;
    logic       req0_val, req0_wr, req1_val, req1_wr;
    logic [1:0] req0_addr, req1_addr;
    logic [3:0] req0_wdata, req1_wdata;
    logic       req0_rdy, req1_rdy, init_done;
    logic       resp0_val, resp1_val, rf_wen;
    logic [3:0] resp0_data, resp1_data, rf_wdata, rf_rdata;
    logic [1:0] rf_waddr, rf_raddr;
    logic [3:0] rf [NR];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_arb_1r1w #(.p_nbits(4), .p_nregs(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .init_done  (init_done),
        .req0_val   (req0_val),
        .req0_rdy   (req0_rdy),
        .req0_wr    (req0_wr),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_val   (req1_val),
        .req1_rdy   (req1_rdy),
        .req1_wr    (req1_wr),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .resp0_val  (resp0_val),
        .resp0_data (resp0_data),
        .resp1_val  (resp1_val),
        .resp1_data (resp1_data),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata)
    );

    // Register file storage driven by the controller.
    assign rf_rdata = rf[rf_raddr];
    always @(posedge clk) if (rf_wen) rf[rf_waddr] <= rf_wdata;

    typedef struct {
        int i_rst, i_clr, v0, w0, a0, d0, v1, w1, a1, d1;
        int e_rdy0, e_rdy1, e_wen, e_waddr, e_wdata, e_raddr, e_done, e_rv0, e_rd0, e_rv1, e_rd1;
    } vec_t;
    vec_t tbl [NV];

    // Reference model: sweep position, priority holder, memory image, pending responses.
    bit m_serve;
    int m_idx, m_prio;
    int m_mem [NR];
    int m_rv [2];
    int m_rd [2];
    bit m_cmp = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        m_serve = 1'b0; m_idx = 0; m_prio = 0;
        m_rv = '{0, 0}; m_rd = '{0, 0};
    endtask

    task automatic drive(input int v0, w0, a0, d0, v1, w1, a1, d1);
        req0_val = v0[0]; req0_wr = w0[0]; req0_addr = a0[1:0]; req0_wdata = d0[3:0];
        req1_val = v1[0]; req1_wr = w1[0]; req1_addr = a1[1:0]; req1_wdata = d1[3:0];
    endtask

    task automatic model_cycle();
        int v [2];
        int w [2];
        int a [2];
        int d [2];
        int e_rdy [2];
        int nrv [2];
        int e_wen, e_waddr, e_wdata, e_raddr, e_done, g;
        v = '{int'(req0_val), int'(req1_val)};
        w = '{int'(req0_wr), int'(req1_wr)};
        a = '{int'(req0_addr), int'(req1_addr)};
        d = '{int'(req0_wdata), int'(req1_wdata)};
        if (rst) m_reset();
        e_wen = 0; e_waddr = 0; e_wdata = 0; e_raddr = 0; e_done = 0; g = -1;
        e_rdy = '{0, 0};
        if (m_serve) begin
            e_done = 1;
            // a port is held off only when the other one is asking and owns priority
            e_rdy[0] = (v[1] != 0 && m_prio == 1) ? 0 : 1;
            e_rdy[1] = (v[0] != 0 && m_prio == 0) ? 0 : 1;
            if (v[0] != 0 && v[1] != 0) g = m_prio;
            else if (v[0] != 0) g = 0;
            else if (v[1] != 0) g = 1;
            if (g >= 0) begin
                if (w[g] != 0) begin e_wen = 1; e_waddr = a[g]; e_wdata = d[g]; end
                else e_raddr = a[g];
            end
        end else begin
            e_wen = 1; e_waddr = m_idx;
        end
        if (m_cmp) begin
            chk("rdy0", int'(req0_rdy), e_rdy[0]);
            chk("rdy1", int'(req1_rdy), e_rdy[1]);
            chk("init_done", int'(init_done), e_done);
            chk("rf_wen", int'(rf_wen), e_wen);
            chk("rf_waddr", int'(rf_waddr), e_waddr);
            chk("rf_wdata", int'(rf_wdata), e_wdata);
            chk("rf_raddr", int'(rf_raddr), e_raddr);
            chk("resp0_val", int'(resp0_val), m_rv[0]);
            chk("resp0_data", int'(resp0_data), m_rd[0]);
            chk("resp1_val", int'(resp1_val), m_rv[1]);
            chk("resp1_data", int'(resp1_data), m_rd[1]);
        end
        if (rst) begin
            m_mem[0] = 0;
            return;
        end
        nrv = '{0, 0};
        if (!m_serve) begin
            m_mem[m_idx] = 0;
            if (m_idx == NR - 1) begin m_serve = 1'b1; m_idx = 0; end
            else m_idx++;
        end else if (g >= 0) begin
            if (w[g] != 0) begin
                $display("%0t p%0d wr addr=%0d data=%0h", $time, g, a[g], d[g]);
                m_mem[a[g]] = d[g];
            end else begin
                $display("%0t p%0d rd addr=%0d data=%0h", $time, g, a[g], m_mem[a[g]]);
                nrv[g] = 1;
                m_rd[g] = m_mem[a[g]];
            end
            m_prio = 1 - g;
        end
        m_rv = nrv;
        if (clear) begin m_serve = 1'b0; m_idx = 0; end
    endtask

    task automatic tick();
        #1;
        model_cycle();
        @(negedge clk);
    endtask

    initial begin
        tbl = '{
            '{1,0, 0,0,0,0,  0,0,0,0,  0,0,1,0,0,0,0,0,0,0,0},
            '{0,0, 0,0,0,0,  0,0,0,0,  0,0,1,0,0,0,0,0,0,0,0},
            '{0,0, 0,0,0,0,  0,0,0,0,  0,0,1,1,0,0,0,0,0,0,0},
            '{0,0, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,0,0,0,0,0,0},
            '{0,0, 0,0,0,0,  0,0,0,0,  0,0,1,3,0,0,0,0,0,0,0},
            '{0,0, 0,0,0,0,  0,0,0,0,  1,1,0,0,0,0,1,0,0,0,0},
            '{0,0, 1,0,2,0,  0,0,0,0,  1,0,0,0,0,2,1,0,0,0,0},
            '{0,0, 1,1,1,10, 0,0,0,0,  1,1,1,1,10,0,1,1,0,0,0},
            '{0,0, 0,0,0,0,  1,0,1,0,  0,1,0,0,0,1,1,0,0,0,0},
            '{0,0, 0,0,0,0,  0,0,0,0,  1,1,0,0,0,0,1,0,0,1,10},
            '{0,0, 1,1,3,5,  1,0,3,0,  1,0,1,3,5,0,1,0,0,0,10},
            '{0,0, 1,1,3,5,  1,0,3,0,  0,1,0,0,0,3,1,0,0,0,10},
            '{0,0, 1,1,3,5,  1,0,3,0,  1,0,1,3,5,0,1,0,0,1,5},
            '{0,0, 1,1,3,5,  1,0,3,0,  0,1,0,0,0,3,1,0,0,0,5},
            '{0,0, 0,0,0,0,  1,0,0,0,  1,1,0,0,0,0,1,0,0,1,5},
            '{0,0, 1,0,1,0,  1,0,3,0,  1,0,0,0,0,1,1,0,0,1,0},
            '{0,0, 0,0,0,0,  0,0,0,0,  1,1,0,0,0,0,1,1,10,0,0}
        };
        m_reset();
        rst = 1'b0; clear = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Directed table: sweep, basic read/write, alternation, lone requester.
        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].i_rst[0];
            clear = tbl[i].i_clr[0];
            drive(tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("tbl%0d.rdy0", i), int'(req0_rdy), tbl[i].e_rdy0);
            chk($sformatf("tbl%0d.rdy1", i), int'(req1_rdy), tbl[i].e_rdy1);
            chk($sformatf("tbl%0d.rf_wen", i), int'(rf_wen), tbl[i].e_wen);
            chk($sformatf("tbl%0d.rf_waddr", i), int'(rf_waddr), tbl[i].e_waddr);
            chk($sformatf("tbl%0d.rf_wdata", i), int'(rf_wdata), tbl[i].e_wdata);
            chk($sformatf("tbl%0d.rf_raddr", i), int'(rf_raddr), tbl[i].e_raddr);
            chk($sformatf("tbl%0d.init_done", i), int'(init_done), tbl[i].e_done);
            chk($sformatf("tbl%0d.resp0_val", i), int'(resp0_val), tbl[i].e_rv0);
            chk($sformatf("tbl%0d.resp0_data", i), int'(resp0_data), tbl[i].e_rd0);
            chk($sformatf("tbl%0d.resp1_val", i), int'(resp1_val), tbl[i].e_rv1);
            chk($sformatf("tbl%0d.resp1_data", i), int'(resp1_data), tbl[i].e_rd1);
            model_cycle();
            @(negedge clk);
        end
        m_cmp = 1'b1;

        // Clear after writing addr0, with a read transfer in the clear cycle.
        drive(1, 1, 0, 15, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0, 3, 0); clear = 1'b1; tick();
        clear = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("clr_resp1_val", int'(resp1_val), 1);
        for (int i = 0; i < NR; i++) tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("clr_addr0_zero", int'(resp0_data), 0);
        tick();

        // Reset two cycles into a sweep.
        clear = 1'b1; tick(); clear = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1 chk("rst_init_waddr", int'(rf_waddr), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR + 1; i++) tick();

        // Reset asserted between edges while a response is being presented.
        drive(1, 1, 2, 9, 0, 0, 0, 0); tick();
        drive(1, 0, 2, 0, 0, 0, 0, 0);
        #1 model_cycle();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_resp0_val", int'(resp0_val), 0);
        chk("midrst_resp0_data", int'(resp0_data), 0);
        chk("midrst_init_done", int'(init_done), 0);
        m_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 1, 0);
        tick();
        rst = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NR + 1; i++) tick();

        // Random traffic with occasional clear and reset.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            clear = ($urandom_range(0, 31) == 0);
            req0_val = ($urandom_range(0, 3) != 0);
            req0_wr = $urandom_range(0, 1) == 1;
            req0_addr = 2'($urandom_range(0, 3));
            req0_wdata = 4'($urandom);
            req1_val = ($urandom_range(0, 3) != 0);
            req1_wr = $urandom_range(0, 1) == 1;
            req1_addr = 2'($urandom_range(0, 3));
            req1_wdata = 4'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_arb_1r1w.md
Name: regfile_arb_1r1w

Overview:
- Controller that owns the single write port and single read port of a flat 4-word x 4-bit 1r1w register file.
- First sequences a zero-initialisation sweep over all entries.
- Then shares the register file between two requesters (port 0, port 1) using round-robin arbitration and val/rdy request handshakes.
- Read data returns on a registered, fixed-latency response channel per requester.

Parameters:
- p_nbits, 4, data width of each register-file entry
- p_nregs, 4, number of entries; must be a power of two; address width = $clog2(p_nregs)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- clear  input  1  one-cycle pulse; re-runs the zero-initialisation sweep
- init_done  output  1  high once the sweep has completed and requests are being served
- reqN_val  input  1  requester N (N=0,1) has a valid request
- reqN_rdy  output  1  controller accepts requester N's request this cycle
- reqN_wr  input  1  1 = write, 0 = read
- reqN_addr  input  log2(p_nregs)  entry address
- reqN_wdata  input  p_nbits  write data; ignored for reads
- respN_val  output  1  read response valid; one-cycle pulse, no backpressure
- respN_data  output  p_nbits  read data
- rf_wen  output  1  register-file write enable
- rf_waddr  output  log2(p_nregs)  register-file write address
- rf_wdata  output  p_nbits  register-file write data
- rf_raddr  output  log2(p_nregs)  register-file read address
- rf_rdata  input  p_nbits  register-file combinational read data

Behaviour:
- States: INIT, SERVE. Reset values: state=INIT, sweep counter=0, priority pointer=0, respN_val=0, respN_data=0, init_done=0.
- Reset is asynchronous: asserting rst mid-operation immediately forces the reset values above. Any in-flight response is dropped.
- INIT:
  - rf_wen=1, rf_waddr=counter, rf_wdata=0. The counter increments each cycle.
  - When counter == p_nregs-1, the write is performed and the next state is SERVE. The sweep takes exactly p_nregs cycles.
  - reqN_rdy=0 and init_done=0 throughout.
- SERVE: init_done=1.
  - rdy0 = !req1_val || prio==0.
  - rdy1 = !req0_val || prio==1.
  - rdy is independent of the requester's own val. At most one transfer (val && rdy) occurs per cycle.
  - After any transfer, prio points to the non-granted requester. With no transfer, prio holds.
- Write transfer: rf_wen=1, rf_waddr/rf_wdata taken from the granted port, all combinationally in the same cycle. The entry updates at the next clk edge. No response is generated.
- Read transfer:
  - rf_raddr = granted reqN_addr; rf_rdata is captured into respN_data at the clock edge.
  - respN_val=1 for exactly the following cycle (latency 1). respN_data holds its value until the next read by that port.
- rf_raddr when no read transfer occurs: drive 0. rf_wen=0 except on INIT cycles and write transfers.
- Read-after-write to the same address in consecutive cycles returns the new data. The write commits at the edge before the read cycle.
- clear:
  - Sampled in any state. The next state is INIT with counter=0; an INIT in progress restarts from 0.
  - A transfer in the same cycle as clear is still performed. A pending response still appears next cycle.
  - prio is unchanged by clear.
- Both ports idle: no register-file activity.

Decomposition:
- Shared package regfile_arb_pkg: state enum typedef {INIT, SERVE}, plus constants for request type (WR=1, RD=0).
- One natural sub-module, rr_arb_2: a 2-requester round-robin arbiter holding the priority flop. Inputs: val0, val1, xfer, en. Outputs: rdy0, rdy1, grant index.
- The controller instantiates rr_arb_2 and the INIT/SERVE FSM plus the response registers.

Test Plan:
- Reset release, no requests -> rf_wen=1 with waddr 0,1,2,3 and wdata=0 over 4 cycles; init_done rises in cycle 5; then port 0 read addr 2 -> resp0_val next cycle, data 0.
- Port 0 writes addr1=0xA; next cycle port 1 reads addr1 -> resp1_val=1, resp1_data=0xA one cycle later; resp0_val stays 0.
- Both ports hold val for 4 cycles (p0 writes addr3=0x5, p1 reads addr3) -> grants alternate p0,p1,p0,p1 starting with p0; each p1 read returns 0x5.
- Port 1 alone valid while prio==0 -> rdy1=1 immediately, transfer same cycle; prio then points to 0.
- clear pulse during SERVE after writing addr0=0xF -> 4 INIT cycles with rdy=0, init_done=0; subsequent read addr0 returns 0.
- Assert rst two cycles into INIT, and again during a read transfer -> outputs immediately at reset values; no resp_val; the sweep restarts at addr 0.
